spi_work_master: RTL and testbench
==================================

# spi_work_master

SPI initiator for the other end of the miner's SPI link: it drives `spi_clk`, `chip_enable` and `mosi` toward the hashing FPGA's SPI slave and samples `miso`. A write transaction shifts out the 768-bit work message (midstate[0:255] followed by block2[0:511]). A read transaction shifts in the 256-bit result hash. It is used in the host-side bridge and as the active stimulus in system-level benches.

## Interface
- `TX_W`, default 768: write payload width in bits.
- `RX_W`, default 256: read payload width in bits.
- `CLK_DIV`, default 4: `clk` cycles per `spi_clk` half-period. Must be ≥1.
- `CS_SETUP`, default 2: `clk` cycles from `chip_enable` low to the first rising `spi_clk`. Must be ≥1.
- `CS_HOLD`, default 2: `clk` cycles from the last falling `spi_clk` to `chip_enable` high. Must be ≥1.
- `CS_GAP`, default 2: minimum `clk` cycles `chip_enable` stays high between transactions. Must be ≥1.

Ports:
- `clk`  in  1  sole clock. All logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE. A command is accepted when `cmd_valid && cmd_ready`.
- `cmd_read`  in  1  0 = write (send `tx_data`), 1 = read (fill `rx_data`). Sampled only at accept.
- `tx_data`  in  [0:TX_W-1]  write payload. Sampled only at accept. Bit 0 is sent first.
- `rx_data`  out  [0:RX_W-1]  last read payload. The first bit received lands in bit 0.
- `done`  out  1  one-cycle pulse at transaction end.
- `busy`  out  1  high from accept until `done`, inclusive.
- `spi_clk`  out  1  SPI clock, mode 0 (idles low).
- `chip_enable`  out  1  slave select, active-low (low = selected).
- `mosi`  out  1  serial data to the slave.
- `miso`  in  1  serial data from the slave. Treated as synchronous to `clk`.

## Operation
- States: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → HOLD → GAP → IDLE.
- IDLE:
  - On accept, latch `tx_data` into the shift register, latch `cmd_read`, load the bit counter with N (TX_W for write, RX_W for read), and go to SETUP.
- SETUP (CS_SETUP cycles):
  - `chip_enable`=0 and `spi_clk`=0.
  - `mosi` = shift register bit 0 for a write, 0 for a read.
- SHIFT_HI (CLK_DIV cycles):
  - `spi_clk`=1. The slave samples `mosi` on this rising edge.
  - For a read, the master captures `miso` in the first cycle of SHIFT_HI and shifts it into the receive register.
  - On exit, decrement the counter. If zero, go to HOLD; otherwise go to SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles):
  - `spi_clk`=0.
  - In the first cycle, the write shift register advances so `mosi` presents the next bit.
  - Then go to SHIFT_HI.
- HOLD (CS_HOLD cycles):
  - `spi_clk`=0 and `chip_enable`=0.
  - `mosi` holds the last bit for a write and stays 0 for a read.
- On HOLD exit:
  - `chip_enable`=1, `mosi`=0, `done`=1 for one cycle.
  - For a read, `rx_data` is updated in the same cycle.
  - Then go to GAP.
- GAP: lasts CS_GAP cycles, then IDLE.
- `rx_data` is unchanged by writes and holds its value until the next read completes.
- Exactly N rising `spi_clk` edges occur per transaction. `spi_clk` never toggles while `chip_enable`=1.
- `cmd_valid` while not ready is ignored. `tx_data` and `cmd_read` changes after accept have no effect.

## Timing
- Reset values while `rst`=0:
  - State is IDLE.
  - `cmd_ready`=1, `busy`=0, `done`=0.
  - `spi_clk`=0, `chip_enable`=1, `mosi`=0.
  - `rx_data`=0, all counters 0.
- Reset mid-transaction: all outputs take their reset values immediately (asynchronously). There is no `done` pulse and no `rx_data` update.
- Relative to accept at cycle 0:
  - `chip_enable` falls at cycle 1.
  - The first rising `spi_clk` is at cycle CS_SETUP+1.
  - Rising edges recur every 2·CLK_DIV cycles.
  - The last falling `spi_clk` is at cycle CS_SETUP+1+(2N−1)·CLK_DIV.
  - `done` and `chip_enable` rise at cycle CS_SETUP+1+(2N−1)·CLK_DIV+CS_HOLD.
  - `cmd_ready` returns CS_GAP cycles after `done`.
- Default latencies:
  - Write: `done` at cycle 6145.
  - Read: `done` at cycle 2049.
  - Next accept possible at `done`+2.
- Counter width: ceil(log2(max(TX_W,RX_W)+1)) bits. Divider width: ceil(log2(CLK_DIV+1)) bits.

## Test plan
- Reset check: hold `rst`=0 with random inputs → `chip_enable`=1, `spi_clk`=0, `mosi`=0, `cmd_ready`=1, `rx_data`=0 throughout.
- Default write: `tx_data` = midstate 0x6a09e667…, block2 0x80000000…0280. The bench slave samples `mosi` on every rising `spi_clk` → exactly 768 bits equal to `tx_data` in order 0..767, `done` at cycle 6145, `rx_data` unchanged.
- Default read: the slave drives hash 0xA5A5…A5 (256 bits) on `miso`, updating after each falling edge → `rx_data` = 0xA5A5…A5, `done` at cycle 2049, `mosi`=0 throughout.
- Back-to-back commands: hold `cmd_valid`=1 (write then read) → second accept exactly 2 cycles after the first `done`, `chip_enable` high ≥2 cycles between transactions, no lost or extra `spi_clk` edges.
- Reset mid-transfer: assert `rst` at bit 300 of a write → outputs go to reset values immediately with no `done` pulse; a fresh write after release completes correctly.
- Edge parameters: CLK_DIV=1, CS_SETUP=CS_HOLD=CS_GAP=1, TX_W=8 with `tx_data`=0xC3, and `tx_data`/`cmd_read` toggled while busy → bits 1,1,0,0,0,0,1,1 sent, `done` at cycle 18.

Source files
------------

// File: rtl/spi_work_master.sv
// SPI mode-0 initiator for the hashing FPGA link: shifts a TX_W-bit work message out on mosi,
// or a RX_W-bit result in from miso, framed by chip_enable setup/hold/gap timing.
module spi_work_master #(
    parameter int unsigned TX_W     = 768,
    parameter int unsigned RX_W     = 256,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_read_i,
    input  logic [0:TX_W-1] tx_data_i,
    output logic [0:RX_W-1] rx_data_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            spi_clk_o,
    output logic            chip_enable_o,
    output logic            mosi_o,
    input  logic            miso_i
);

    localparam int unsigned MaxW   = (TX_W > RX_W) ? TX_W : RX_W;
    localparam int unsigned CntW   = $clog2(MaxW + 1);
    localparam int unsigned TmrA   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned TmrB   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned TmrMax = (TmrA > TmrB) ? TmrA : TmrB;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [TmrW-1:0] DivLoad   = TmrW'(CLK_DIV - 1);
    localparam logic [TmrW-1:0] SetupLoad = TmrW'(CS_SETUP - 1);
    localparam logic [TmrW-1:0] HoldLoad  = TmrW'(CS_HOLD - 1);
    localparam logic [TmrW-1:0] GapLoad   = TmrW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftHi,
        StShiftLo,
        StHold,
        StGap
    } state_e;

    state_e          state_q;
    logic [TmrW-1:0] tmr_q;
    logic [CntW-1:0] bits_q;
    logic [0:TX_W-1] tx_q;
    logic [0:RX_W-1] rx_sh_q;
    logic [0:RX_W-1] rx_q;
    logic            read_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            sclk_q;
    logic            ce_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            read_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ce_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        state_q <= StSetup;
                        tmr_q   <= SetupLoad;
                        bits_q  <= cmd_read_i ? CntW'(RX_W) : CntW'(TX_W);
                        // mosi is tx_q[0]; a read keeps the line low by loading zeros
                        tx_q    <= cmd_read_i ? '0 : tx_data_i;
                        read_q  <= cmd_read_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ce_q    <= 1'b0;
                    end
                end
                StSetup: begin
                    if (tmr_q == '0) begin
                        state_q <= StShiftHi;
                        tmr_q   <= DivLoad;
                        sclk_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                StShiftHi: begin
                    if (read_q && tmr_q == DivLoad) begin
                        rx_sh_q <= {rx_sh_q[1:RX_W-1], miso_i};
                    end
                    if (tmr_q == '0) begin
                        sclk_q <= 1'b0;
                        bits_q <= bits_q - CntW'(1);
                        if (bits_q == CntW'(1)) begin
                            state_q <= StHold;
                            tmr_q   <= HoldLoad;
                        end else begin
                            state_q <= StShiftLo;
                            tmr_q   <= DivLoad;
                            tx_q    <= tx_q << 1;
                        end
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                StShiftLo: begin
                    if (tmr_q == '0) begin
                        state_q <= StShiftHi;
                        tmr_q   <= DivLoad;
                        sclk_q  <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                StHold: begin
                    if (tmr_q == '0) begin
                        state_q <= StGap;
                        tmr_q   <= GapLoad;
                        ce_q    <= 1'b1;
                        tx_q    <= '0;
                        done_q  <= 1'b1;
                        if (read_q) begin
                            rx_q <= rx_sh_q;
                        end
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                StGap: begin
                    busy_q <= 1'b0;
                    if (tmr_q == '0) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - TmrW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign spi_clk_o     = sclk_q;
    assign chip_enable_o = ce_q;
    assign mosi_o        = tx_q[0];
    assign rx_data_o     = rx_q;

endmodule

// File: tb/tb_spi_work_master.sv
// Bench for spi_work_master: a default-parameter instance and a minimal-timing instance, both
// checked every cycle against a timeline model derived from the transfer timing rules.
module tb_spi_work_master;

    localparam int unsigned ETX = 8;
    localparam int unsigned ERX = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn [2];
    logic vld  [2];
    logic rd   [2];
    logic miso [2];
    logic rdy  [2];
    logic dn   [2];
    logic bsy  [2];
    logic sck  [2];
    logic ce   [2];
    logic mo   [2];
    logic [0:767]   txs  [2];
    logic [0:255]   hash [2];
    logic [0:ETX-1] tx1;
    logic [0:255]   rx0;
    logic [0:ERX-1] rx1;

    assign tx1 = txs[1][0:ETX-1];

    spi_work_master u_dut (
        .clk_i        (clk),
        .rst_ni       (rstn[0]),
        .cmd_valid_i  (vld[0]),
        .cmd_ready_o  (rdy[0]),
        .cmd_read_i   (rd[0]),
        .tx_data_i    (txs[0]),
        .rx_data_o    (rx0),
        .done_o       (dn[0]),
        .busy_o       (bsy[0]),
        .spi_clk_o    (sck[0]),
        .chip_enable_o(ce[0]),
        .mosi_o       (mo[0]),
        .miso_i       (miso[0])
    );

    spi_work_master #(
        .TX_W    (ETX),
        .RX_W    (ERX),
        .CLK_DIV (1),
        .CS_SETUP(1),
        .CS_HOLD (1),
        .CS_GAP  (1)
    ) u_edge (
        .clk_i        (clk),
        .rst_ni       (rstn[1]),
        .cmd_valid_i  (vld[1]),
        .cmd_ready_o  (rdy[1]),
        .cmd_read_i   (rd[1]),
        .tx_data_i    (tx1),
        .rx_data_o    (rx1),
        .done_o       (dn[1]),
        .busy_o       (bsy[1]),
        .spi_clk_o    (sck[1]),
        .chip_enable_o(ce[1]),
        .mosi_o       (mo[1]),
        .miso_i       (miso[1])
    );

    int p_tx [2] = '{768, ETX};
    int p_rx [2] = '{256, ERX};
    int p_k  [2] = '{4, 1};
    int p_s  [2] = '{2, 1};
    int p_h  [2] = '{2, 1};
    int p_g  [2] = '{2, 1};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state (written only by the posedge model process)
    bit           m_act  [2];
    int           m_acc  [2];
    bit           m_read [2];
    logic [0:767] m_tx   [2];
    logic [0:255] m_rx   [2];
    logic [0:255] m_hash [2];
    int           acc_cnt[2];
    // observation state (written only by the negedge compare/slave process)
    int           done_cnt[2];
    int           done_cyc[2];
    int           rises   [2];
    int           sidx    [2];
    logic         psck    [2];
    logic [0:767] rbits   [2];

    logic [5:0]   me, ee;
    logic [0:767] gb, wb;
    logic [0:255] gr, er;
    int           nb;

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int done_off(input int i, input bit r);
        int n;
        n = r ? p_rx[i] : p_tx[i];
        return p_s[i] + 1 + (2 * n - 1) * p_k[i] + p_h[i];
    endfunction

    // {ready, busy, done, chip_enable, spi_clk, mosi} expected during cycle c
    function automatic logic [5:0] model_out(input int i, input int c);
        int t, n, d, lastc, ph;
        logic [5:0] e;
        e = 6'b100100;
        ph = 0;
        if (rstn[i] !== 1'b1 || !m_act[i]) return e;
        t = c - m_acc[i];
        n = m_read[i] ? p_rx[i] : p_tx[i];
        lastc = p_s[i] + 1 + (2 * n - 1) * p_k[i];
        d = lastc + p_h[i];
        if (t <= 0 || t >= d + p_g[i]) return e;
        e[5] = 1'b0;
        e[4] = (t <= d);
        e[3] = (t == d);
        e[2] = (t >= d);
        if (t > p_s[i] && t < lastc) begin
            ph = (t - p_s[i] - 1) / p_k[i];
            e[1] = (ph % 2 == 0);
        end
        if (!m_read[i] && t < d) begin
            if (t <= p_s[i]) e[0] = m_tx[i][0];
            else if (t < lastc) e[0] = m_tx[i][(ph + 1) / 2];
            else e[0] = m_tx[i][n - 1];
        end
        return e;
    endfunction

    function automatic logic [0:767] rand768();
        logic [0:767] r;
        for (int w = 0; w < 24; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // model: accept decisions and rx_data updates at each rising clk
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            me = model_out(i, cyc);
            if (rstn[i] !== 1'b1) begin
                m_act[i] = 1'b0;
                m_rx[i]  = '0;
            end else if (me[5] && vld[i] === 1'b1) begin
                m_act[i]  = 1'b1;
                m_acc[i]  = cyc;
                m_read[i] = rd[i];
                m_tx[i]   = txs[i];
                m_hash[i] = hash[i];
                acc_cnt[i]++;
            end
        end
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (m_act[i] && m_read[i] && cyc - m_acc[i] == done_off(i, 1'b1)) begin
                m_rx[i] = '0;
                for (int b = 0; b < p_rx[i]; b++) m_rx[i][b] = m_hash[i][b];
            end
        end
    end

    // compare every output on the falling edge, then act as the SPI slave
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ee = model_out(i, cyc);
            chk($sformatf("u%0d cmd_ready", i), rdy[i], ee[5]);
            chk($sformatf("u%0d busy", i), bsy[i], ee[4]);
            chk($sformatf("u%0d done", i), dn[i], ee[3]);
            chk($sformatf("u%0d chip_enable", i), ce[i], ee[2]);
            chk($sformatf("u%0d spi_clk", i), sck[i], ee[1]);
            chk($sformatf("u%0d mosi", i), mo[i], ee[0]);
            gr = (i == 0) ? rx0 : {rx1, {(256 - ERX){1'b0}}};
            er = (rstn[i] === 1'b1) ? m_rx[i] : '0;
            chk($sformatf("u%0d rx_data", i), gr, er);
            if (dn[i] === 1'b1) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            if (ee[3] && rstn[i] === 1'b1) begin
                nb = m_read[i] ? p_rx[i] : p_tx[i];
                chk($sformatf("u%0d spi_clk rises", i), rises[i], nb);
                if (!m_read[i]) begin
                    gb = '0;
                    wb = '0;
                    for (int b = 0; b < nb; b++) begin
                        gb[b] = rbits[i][b];
                        wb[b] = m_tx[i][b];
                    end
                    chk($sformatf("u%0d bits seen by slave", i), gb, wb);
                end
            end
            if (ce[i] !== 1'b0) begin
                rises[i] = 0;
                sidx[i]  = 0;
                miso[i]  = hash[i][0];
            end else begin
                if (sck[i] === 1'b1 && psck[i] === 1'b0) begin
                    if (rises[i] < 768) rbits[i][rises[i]] = mo[i];
                    rises[i]++;
                end
                if (sck[i] === 1'b0 && psck[i] === 1'b1) begin
                    sidx[i]++;
                    miso[i] = (sidx[i] < 256) ? hash[i][sidx[i]] : 1'b0;
                end
            end
            psck[i] = sck[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic r, input logic [0:767] d, input bit keep);
        int a0;
        a0 = acc_cnt[i];
        vld[i] = 1'b1;
        rd[i]  = r;
        txs[i] = d;
        for (int k = 0; k < 100 && acc_cnt[i] == a0; k++) tick();
        if (!keep) vld[i] = 1'b0;
        chk($sformatf("u%0d command accepted", i), acc_cnt[i] - a0, 1);
    endtask

    task automatic wait_done(input int i, input bit toggle, input int limit);
        int d0;
        d0 = done_cnt[i];
        for (int k = 0; k < limit && done_cnt[i] == d0; k++) begin
            tick();
            if (toggle) begin
                txs[i] = rand768();
                rd[i]  = 1'($urandom_range(0, 1));
            end
        end
        chk($sformatf("u%0d done within bound", i), done_cnt[i] != d0, 1);
    endtask

    logic [0:767] golden, tmp;
    int           d1, a1, dc;

    initial begin
        golden = {256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
                  32'h80000000, 448'h0, 32'h00000280};
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b1;
            vld[i]  = 1'b0;
            rd[i]   = 1'b0;
            txs[i]  = '0;
            hash[i] = '0;
            miso[i] = 1'b0;
            psck[i] = 1'b0;
        end
        #1;
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;

        // reset held with random inputs
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                vld[i] = 1'($urandom_range(0, 1));
                rd[i]  = 1'($urandom_range(0, 1));
                txs[i] = rand768();
            end
        end
        chk("reset chip_enable", ce[0], 1'b1);
        chk("reset rx_data", rx0, 256'h0);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        tick();
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // default write of the reference work message
        issue(0, 1'b0, golden, 1'b0);
        wait_done(0, 1'b0, 7000);
        chk("write done latency", done_cyc[0] - m_acc[0], 6145);
        tmp = rbits[0];
        chk("first nibble on mosi", tmp[0:3], 4'h6);
        chk("rx_data after write", rx0, 256'h0);
        for (int k = 0; k < 3; k++) tick();

        // default read of an A5 hash
        hash[0] = {32{8'hA5}};
        issue(0, 1'b1, rand768(), 1'b0);
        wait_done(0, 1'b0, 3000);
        chk("read done latency", done_cyc[0] - m_acc[0], 2049);
        chk("read data A5", rx0, {32{8'hA5}});
        for (int k = 0; k < 3; k++) tick();

        // back-to-back: valid held, write then read
        tmp = rand768();
        issue(0, 1'b0, tmp, 1'b1);
        rd[0] = 1'b1;
        tmp = rand768();
        hash[0] = tmp[0:255];
        wait_done(0, 1'b0, 7000);
        d1 = done_cyc[0];
        a1 = acc_cnt[0];
        for (int k = 0; k < 20 && acc_cnt[0] == a1; k++) tick();
        vld[0] = 1'b0;
        chk("second accept seen", acc_cnt[0] - a1, 1);
        chk("accept-to-done gap", m_acc[0] - d1, 2);
        wait_done(0, 1'b0, 3000);
        chk("back-to-back read data", rx0, hash[0]);
        for (int k = 0; k < 3; k++) tick();

        // reset in the middle of a write
        issue(0, 1'b0, golden, 1'b0);
        for (int k = 0; k < 4000 && rises[0] < 300; k++) tick();
        chk("reached bit 300", rises[0] >= 300, 1'b1);
        dc = done_cnt[0];
        rstn[0] = 1'b0;
        #1;
        chk("async reset chip_enable", ce[0], 1'b1);
        chk("async reset spi_clk", sck[0], 1'b0);
        chk("async reset mosi", mo[0], 1'b0);
        chk("async reset busy", bsy[0], 1'b0);
        chk("async reset cmd_ready", rdy[0], 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            vld[0] = 1'($urandom_range(0, 1));
            rd[0]  = 1'($urandom_range(0, 1));
        end
        vld[0] = 1'b0;
        tick();
        rstn[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("no done across reset", done_cnt[0] - dc, 0);
        issue(0, 1'b0, golden, 1'b0);
        wait_done(0, 1'b0, 7000);
        chk("write after reset latency", done_cyc[0] - m_acc[0], 6145);

        // minimal timing: 0xC3 with inputs toggling while busy
        tmp = '0;
        tmp[0:7] = 8'hC3;
        issue(1, 1'b0, tmp, 1'b0);
        wait_done(1, 1'b1, 100);
        chk("edge done latency", done_cyc[1] - m_acc[1], 18);
        tmp = rbits[1];
        chk("edge bits sent", tmp[0:7], 8'hC3);
        rd[1] = 1'b0;
        for (int k = 0; k < 2; k++) tick();

        // randomized traffic on the minimal-timing instance
        for (int n = 0; n < 40; n++) begin
            tmp = rand768();
            hash[1] = tmp[0:255];
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
            issue(1, 1'($urandom_range(0, 1)), rand768(), 1'b0);
            wait_done(1, 1'($urandom_range(0, 1)), 100);
        end

        // one randomized default read
        tmp = rand768();
        hash[0] = tmp[0:255];
        issue(0, 1'b1, rand768(), 1'b0);
        wait_done(0, 1'b0, 3000);
        chk("random read data", rx0, hash[0]);
        for (int k = 0; k < 4; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
